fifo_write_arbiter: RTL

- Shares the single write port of the team's FIFO (write-clock side) among NUM_REQ producers, e.g. several sine generators.
- Arbitration is round-robin; each grant is a burst of up to MAX_BURST words.
- Drives the FIFO's write enable and data, respecting its full flag.
- Sits between the producers and the FIFO write interface, entirely in the write-clock domain.

---
 rtl/fifo_arb_pkg.sv | 7 +
 rtl/rr_picker.sv | 31 +++
 rtl/fifo_write_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and index-width helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, scanning upward from the slot after last_owner
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any_req
);
  logic found;
  logic [IW-1:0] k;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    k = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IW'((int'(last_owner) + i) % NUM_REQ);
      if (!found && req[k]) begin
        found = 1'b1;
        grant[k] = 1'b1;
        idx = k;
      end
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST = 8,
  localparam int IW = idx_w(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_REQ-1:0]            last_i,
  output logic [NUM_REQ-1:0]            ack_o,
  input  logic                          full_i,
  output logic                          we_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [IW-1:0]                 src_id_o,
  output logic                          busy_o
);
  arb_state_t state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt, pick_grant;
  logic [IW-1:0] src_nxt, last_owner, last_owner_nxt, pick_idx;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic any_req, in_burst, owner_req, burst_end;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_i),
    .last_owner(last_owner),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_req   (any_req)
  );

  assign in_burst = state == BURST;
  assign owner_req = req_i[src_id_o];
  assign we_o = in_burst & owner_req & ~full_i & ~rst_i;
  assign ack_o = we_o ? grant_o : '0;
  assign data_o = we_o ? words[src_id_o] : '0;
  assign busy_o = in_burst;
  // beat_cnt counts writes already done, so the write taking it to MAX_BURST is seen at MAX_BURST-1
  assign burst_end = in_burst & (~owner_req | (we_o & (last_i[src_id_o] | beat_cnt == BW'(MAX_BURST - 1))));

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_o;
    src_nxt = src_id_o;
    last_owner_nxt = last_owner;
    beat_nxt = beat_cnt;
    if (!in_burst && any_req) begin
      state_nxt = BURST;
      grant_nxt = pick_grant;
      src_nxt = pick_idx;
      beat_nxt = '0;
    end else if (burst_end) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      src_nxt = '0;
      last_owner_nxt = src_id_o;
      beat_nxt = '0;
    end else if (we_o) begin
      beat_nxt = beat_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant_o <= '0;
      src_id_o <= '0;
      last_owner <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      grant_o <= grant_nxt;
      src_id_o <= src_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt <= beat_nxt;
    end
  end
endmodule
